// File: rtl/alu_issue_seq.sv
// Instruction issue sequencer: register file, ALU operand/opcode driver and writeback response channel.
// Optional macro ALU_ISSUE_SEQ_FLAGS_EN adds registered out_zero/out_neg response flags.
module alu_issue_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 4,
  parameter int unsigned RAW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [RAW-1:0]   in_dst,
  input  logic [RAW-1:0]   in_src_a,
  input  logic [RAW-1:0]   in_src_b,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [RAW-1:0]   out_dst,
  output logic             err_illegal
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_RST   = 4'b0001;
  localparam logic [3:0] OP_LOADI = 4'b0010;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b0101) || ((op >= 4'b1000) && (op <= 4'b1101));
  endfunction

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   rf [NREGS];
  logic [RAW-1:0]     dst_q;
  logic               accept;
  logic               load_out;
  logic [WIDTH-1:0]   load_val;
  logic [RAW-1:0]     load_dst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) begin
        if (is_alu_op(in_opcode))       state_nxt = EXEC;
        else if (in_opcode == OP_LOADI) state_nxt = RESP;
      end
      EXEC: state_nxt = RESP;
      RESP: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response capture is shared by LOADI (from the immediate) and the end of EXEC (from the ALU).
  always_comb begin
    in_ready = (state == IDLE);
    accept   = in_valid && in_ready;
    load_out = 1'b0;
    load_val = in_imm;
    load_dst = in_dst;
    if (state == EXEC) begin
      load_out = 1'b1;
      load_val = alu_result;
      load_dst = dst_q;
    end else if (accept && (in_opcode == OP_LOADI)) begin
      load_out = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf          <= '{default: '0};
      dst_q       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= OP_NOP;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_dst     <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (load_out) begin
        rf[load_dst] <= load_val;
        out_data     <= load_val;
        out_dst      <= load_dst;
        out_valid    <= 1'b1;
      end
      unique case (state)
        IDLE: if (accept) begin
          if (is_alu_op(in_opcode)) begin
            alu_a      <= rf[in_src_a];
            alu_b      <= rf[in_src_b];
            alu_opcode <= in_opcode;
            dst_q      <= in_dst;
          end else if (in_opcode == OP_RST) begin
            rf <= '{default: '0};
          end else if ((in_opcode != OP_NOP) && (in_opcode != OP_LOADI)) begin
            err_illegal <= 1'b1;
          end
        end
        EXEC: begin
          alu_a      <= '0;
          alu_b      <= '0;
          alu_opcode <= OP_NOP;
        end
        RESP: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_SEQ_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
    end else if (load_out) begin
      out_zero <= (load_val == '0);
      out_neg  <= load_val[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed self-checking bench for alu_issue_seq with a behavioural 16-bit ALU attached.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [1:0]  in_dst, in_src_a, in_src_b;
  logic [15:0] in_imm;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_opcode;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_dst;
  logic        err_illegal;
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
  logic        out_zero, out_neg;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] r_data;
  logic [1:0]  r_dst;
  int          r_lat;
  logic [3:0]  r_exop, r_respop;
  logic        r_exrdy;
  logic        r_zero, r_neg;

  localparam logic [3:0] NOP = 4'h0, RSTOP = 4'h1, LOADI = 4'h2, ADD = 4'h4, SUB = 4'h5;
  localparam logic [3:0] AND_ = 4'h8, OR_ = 4'h9, XOR_ = 4'hA, NAND_ = 4'hB, NOR_ = 4'hC, NOT_ = 4'hD;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_opcode)
      4'h4:    alu_result = alu_a + alu_b;
      4'h5:    alu_result = alu_a - alu_b;
      4'h8:    alu_result = alu_a & alu_b;
      4'h9:    alu_result = alu_a | alu_b;
      4'hA:    alu_result = alu_a ^ alu_b;
      4'hB:    alu_result = ~(alu_a & alu_b);
      4'hC:    alu_result = ~(alu_a | alu_b);
      4'hD:    alu_result = ~alu_a;
      default: alu_result = 16'h0000;
    endcase
  end

  alu_issue_seq #(.WIDTH(16), .NREGS(4), .RAW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dst(in_dst), .in_src_a(in_src_a), .in_src_b(in_src_b), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dst(out_dst),
    .err_illegal(err_illegal)
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
    , .out_zero(out_zero), .out_neg(out_neg)
`endif
  );

  task automatic issue(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                       input logic [1:0] b, input logic [15:0] imm);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_dst = d; in_src_a = a; in_src_b = b; in_imm = imm;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Issues one instruction, waits (bounded) for its response, records it and acknowledges it.
  task automatic run_op(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                        input logic [1:0] b, input logic [15:0] imm);
    issue(op, d, a, b, imm);
    r_lat   = 1;
    r_exop  = alu_opcode;
    r_exrdy = in_ready;
    while (out_valid !== 1'b1 && r_lat < 20) begin
      @(negedge clk);
      r_lat++;
    end
    r_data   = out_data;
    r_dst    = out_dst;
    r_respop = alu_opcode;
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
    r_zero = out_zero;
    r_neg  = out_neg;
`else
    r_zero = 1'b0;
    r_neg  = 1'b0;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_opcode = 4'h0; in_dst = '0; in_src_a = '0; in_src_b = '0;
    in_imm = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, alu_opcode, alu_a, alu_b, out_data, out_dst, err_illegal} !==
        {1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 2'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b ov=%b op=%h a=%h b=%h d=%h dst=%h err=%b, expected 1 0 0 0 0 0 0 0",
               in_ready, out_valid, alu_opcode, alu_a, alu_b, out_data, out_dst, err_illegal);
    end
    rst = 1'b0;
  endtask

  task automatic test_loadi_add;
    run_op(LOADI, 2'd0, 2'd0, 2'd0, 16'h0005);
    n_cmp++; if ({r_data, r_dst} !== {16'h0005, 2'd0}) begin n_fail++; $display("FAIL loadi_r0: got %h/r%0d expected 0005/r0", r_data, r_dst); end
    n_cmp++; if (r_lat !== 1) begin n_fail++; $display("FAIL loadi_latency: got %0d expected 1", r_lat); end
    run_op(LOADI, 2'd1, 2'd0, 2'd0, 16'h0003);
    n_cmp++; if ({r_data, r_dst} !== {16'h0003, 2'd1}) begin n_fail++; $display("FAIL loadi_r1: got %h/r%0d expected 0003/r1", r_data, r_dst); end
    run_op(ADD, 2'd2, 2'd0, 2'd1, 16'h0000);
    n_cmp++; if ({r_data, r_dst} !== {16'h0008, 2'd2}) begin n_fail++; $display("FAIL add: got %h/r%0d expected 0008/r2", r_data, r_dst); end
    n_cmp++; if (r_lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", r_lat); end
    n_cmp++; if ({r_exop, r_exrdy, r_respop} !== {ADD, 1'b0, 4'h0}) begin n_fail++; $display("FAIL add_exec_pins: got op=%h rdy=%b respop=%h expected 4 0 0", r_exop, r_exrdy, r_respop); end
  endtask

  task automatic test_sub;
    run_op(SUB, 2'd3, 2'd1, 2'd0, 16'h0000);
    n_cmp++; if ({r_data, r_dst} !== {16'hFFFE, 2'd3}) begin n_fail++; $display("FAIL sub_wrap: got %h/r%0d expected fffe/r3", r_data, r_dst); end
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
    n_cmp++; if ({r_zero, r_neg} !== 2'b01) begin n_fail++; $display("FAIL sub_flags: got z=%b n=%b expected z=0 n=1", r_zero, r_neg); end
`endif
  endtask

  task automatic test_logic;
    logic [3:0]  ops [6] = '{AND_, OR_, XOR_, NAND_, NOR_, NOT_};
    logic [15:0] exp [6] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'hFF0F, 16'h000F, 16'h0F0F};
    run_op(LOADI, 2'd0, 2'd0, 2'd0, 16'hF0F0);
    run_op(LOADI, 2'd1, 2'd0, 2'd0, 16'h0FF0);
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], 2'd2, 2'd0, 2'd1, 16'h0000);
      n_cmp++; if ({r_data, r_dst} !== {exp[i], 2'd2}) begin n_fail++; $display("FAIL logic_op%h: got %h/r%0d expected %h/r2", ops[i], r_data, r_dst, exp[i]); end
      n_cmp++; if ({r_exop, r_respop} !== {ops[i], 4'h0}) begin n_fail++; $display("FAIL logic_opcode%h: got exec=%h resp=%h expected %h 0", ops[i], r_exop, r_respop, ops[i]); end
    end
    run_op(ADD, 2'd2, 2'd2, 2'd2, 16'h0000);
    n_cmp++; if (r_data !== 16'h1E1E) begin n_fail++; $display("FAIL src_eq_dst1: got %h expected 1e1e", r_data); end
    run_op(ADD, 2'd2, 2'd2, 2'd2, 16'h0000);
    n_cmp++; if (r_data !== 16'h3C3C) begin n_fail++; $display("FAIL src_eq_dst2: got %h expected 3c3c", r_data); end
    run_op(LOADI, 2'd3, 2'd0, 2'd0, 16'hFFFF);
    run_op(ADD, 2'd3, 2'd3, 2'd1, 16'h0000);
    n_cmp++; if (r_data !== 16'h0FEF) begin n_fail++; $display("FAIL add_wrap: got %h expected 0fef", r_data); end
    run_op(SUB, 2'd2, 2'd0, 2'd0, 16'h0000);
    n_cmp++; if (r_data !== 16'h0000) begin n_fail++; $display("FAIL sub_zero: got %h expected 0000", r_data); end
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
    n_cmp++; if ({r_zero, r_neg} !== 2'b10) begin n_fail++; $display("FAIL zero_flags: got z=%b n=%b expected z=1 n=0", r_zero, r_neg); end
`endif
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int hs  = 0;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = ADD; in_dst = 2'd2; in_src_a = 2'd0; in_src_b = 2'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (in_ready === 1'b1) acc++;
      if (out_valid === 1'b1) hs++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", acc); end
    n_cmp++; if (hs !== 3) begin n_fail++; $display("FAIL b2b_responses: got %0d expected 3", hs); end
  endtask

  task automatic test_backpressure;
    issue(LOADI, 2'd3, 2'd0, 2'd0, 16'hABCD);
    in_valid = 1'b1; in_opcode = LOADI; in_dst = 2'd0; in_imm = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid, out_data, out_dst, in_ready} !== {1'b1, 16'hABCD, 2'd3, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got ov=%b d=%h dst=%0d rdy=%b expected 1 abcd 3 0", i, out_valid, out_data, out_dst, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL release: got ov=%b rdy=%b expected 0 1", out_valid, in_ready); end
    run_op(ADD, 2'd2, 2'd0, 2'd0, 16'h0000);
    n_cmp++; if (r_data !== 16'hE1E0) begin n_fail++; $display("FAIL no_accept_while_held: got %h expected e1e0", r_data); end
  endtask

  task automatic test_illegal;
    int seen = 0;
    issue(4'h7, 2'd0, 2'd0, 2'd0, 16'h1234);
    repeat (3) begin if (out_valid === 1'b1) seen++; @(negedge clk); end
    issue(4'hF, 2'd1, 2'd0, 2'd0, 16'h5678);
    repeat (3) begin if (out_valid === 1'b1) seen++; @(negedge clk); end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL illegal_no_resp: got %0d responses expected 0", seen); end
    n_cmp++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err_illegal); end
    run_op(LOADI, 2'd3, 2'd0, 2'd0, 16'h0000);
    run_op(ADD, 2'd2, 2'd0, 2'd3, 16'h0000);
    n_cmp++; if (r_data !== 16'hF0F0) begin n_fail++; $display("FAIL illegal_rf_intact: got %h expected f0f0", r_data); end
    issue(NOP, 2'd0, 2'd0, 2'd0, 16'h0000);
    repeat (2) begin if (out_valid === 1'b1) seen++; @(negedge clk); end
    issue(RSTOP, 2'd0, 2'd0, 2'd0, 16'h0000);
    repeat (2) begin if (out_valid === 1'b1) seen++; @(negedge clk); end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL nop_reset_no_resp: got %0d responses expected 0", seen); end
    run_op(ADD, 2'd2, 2'd0, 2'd1, 16'h0000);
    n_cmp++; if (r_data !== 16'h0000) begin n_fail++; $display("FAIL rf_reset_op: got %h expected 0000", r_data); end
    n_cmp++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_illegal); end
  endtask

  task automatic test_rst_mid_exec;
    int seen = 0;
    run_op(LOADI, 2'd0, 2'd0, 2'd0, 16'h0005);
    run_op(LOADI, 2'd1, 2'd0, 2'd0, 16'h0003);
    issue(ADD, 2'd2, 2'd0, 2'd1, 16'h0000);
    n_cmp++;
    if ({alu_opcode, alu_a, alu_b, in_ready} !== {ADD, 16'h0005, 16'h0003, 1'b0}) begin
      n_fail++;
      $display("FAIL exec_operands: got op=%h a=%h b=%h rdy=%b expected 4 0005 0003 0", alu_opcode, alu_a, alu_b, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, alu_opcode, alu_a, alu_b, out_data, out_dst, err_illegal} !==
        {1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 2'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b ov=%b op=%h a=%h b=%h d=%h dst=%h err=%b, expected 1 0 0 0 0 0 0 0",
               in_ready, out_valid, alu_opcode, alu_a, alu_b, out_data, out_dst, err_illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin if (out_valid === 1'b1) seen++; @(negedge clk); end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_resp: got %0d responses expected 0", seen); end
    run_op(ADD, 2'd2, 2'd0, 2'd1, 16'h0000);
    n_cmp++; if ({r_data, r_lat} !== {16'h0000, 32'd2}) begin n_fail++; $display("FAIL post_reset_add: got %h lat %0d expected 0000 lat 2", r_data, r_lat); end
  endtask

  initial begin
    test_reset();
    test_loadi_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_rst_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Instruction issue sequencer that drives the 16-bit ALU's operand and opcode inputs and captures its result.
- It is the initiator side of the ALU interface.
- Owns a small register file, accepts one instruction at a time over a valid/ready handshake, and returns each writeback value over a valid/ready response channel.
- Sits between the test/control logic and the ALU.

Parameters:
WIDTH, 16, datapath width; must match ALU operand width
NREGS, 4, register file depth
RAW, 2, register address width, clog2(NREGS)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  instruction valid
in_ready  output  1  sequencer can accept instruction
in_opcode  input  4  ALU opcode encoding, plus local LOADI 0010
in_dst  input  RAW  destination register
in_src_a  input  RAW  operand A register
in_src_b  input  RAW  operand B register
in_imm  input  WIDTH  immediate for LOADI
alu_a  output  WIDTH  to ALU A
alu_b  output  WIDTH  to ALU B
alu_opcode  output  4  to ALU opcode
alu_result  input  WIDTH  from ALU result (combinational in the ALU)
out_valid  output  1  writeback response valid
out_ready  input  1  response consumer ready
out_data  output  WIDTH  value written to register file
out_dst  output  RAW  register written
err_illegal  output  1  sticky illegal-opcode flag

Behaviour:
Interface and reset
- One clock, clk. Reset rst is asynchronous and active-high.
- On reset, clear immediately (no clock needed): state=IDLE, all rf=0, alu_a=0, alu_b=0, alu_opcode=0000, out_valid=0, out_data=0, out_dst=0, err_illegal=0.
- in_ready=1 after reset.

FSM: IDLE, EXEC, RESP
- IDLE
  - in_ready=1; an instruction is accepted on in_valid&in_ready.
  - Accepted 0000 NOP: no effect, remain IDLE.
  - Accepted 0001 RESET: all rf<=0 at that edge, remain IDLE, no response.
  - Accepted 0010 LOADI: rf[in_dst]<=in_imm; out_data<=in_imm; out_dst<=in_dst; go to RESP.
  - Accepted ALU opcode (0100, 0101, 1000-1101): register alu_a<=rf[src_a], alu_b<=rf[src_b], alu_opcode<=in_opcode, latch dst; go to EXEC.
  - Accepted any other opcode (0011, 0110, 0111, 1110, 1111): err_illegal<=1 (sticky until rst), no writeback, remain IDLE.
- EXEC
  - in_ready=0; ALU inputs stable for the whole cycle.
  - At the end of EXEC, sample alu_result into rf[dst], out_data and out_dst; alu_a, alu_b and alu_opcode return to 0; go to RESP.
- RESP
  - out_valid=1; in_ready=0; out_data and out_dst are held stable until out_ready.
  - On out_valid&out_ready: out_valid<=0, go to IDLE.

Timing
- ALU instruction latency: accept edge to out_valid = 2 cycles.
- LOADI latency: 1 cycle.
- Minimum ALU issue interval: 3 cycles.

Rules and boundary conditions
- Arithmetic and logic results are exactly the ALU's WIDTH-bit results. ADD/SUB wrap modulo 2^WIDTH; no carry is kept.
- NOT uses only A; alu_b is still driven with rf[src_b] and ignored.
- src equal to dst is legal: operands are read before writeback. A following instruction sees the updated value.
- alu_opcode is 0000 (NOP) in every state except EXEC.
- rst asserted in EXEC or RESP aborts the instruction: no writeback, no response, rf cleared.
- out_ready may be held low indefinitely; no instruction is accepted meanwhile.

Optional Feature:
Macro: ALU_ISSUE_SEQ_FLAGS_EN
- Defined: add outputs out_zero (1 bit) and out_neg (1 bit), registered with out_data.
  - out_zero = (out_data==0).
  - out_neg = out_data[WIDTH-1].
  - Both reset to 0 and are valid only while out_valid.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- rst, then LOADI r0=0x0005, LOADI r1=0x0003, ADD(0100) dst r2, src r0,r1 -> responses 0x0005/r0, 0x0003/r1, then 0x0008/r2 with out_valid 2 cycles after accept.
- SUB(0101) dst r3, src r1,r0 -> out_data 0xFFFE; with FLAGS_EN, out_neg=1 and out_zero=0.
- LOADI r0=0xF0F0, LOADI r1=0x0FF0, then AND/OR/XOR/NAND/NOR/NOT into r2 -> 0x00F0, 0xFFF0, 0xFF00, 0xFF0F, 0x000F, 0x0F0F; alu_opcode is nonzero only in EXEC.
- Hold out_ready=0 for 5 cycles during RESP -> out_data and out_dst stable, in_ready=0 throughout; release -> one handshake, then in_ready=1.
- Issue opcode 0111 -> err_illegal=1 and stays 1, no out_valid, rf unchanged (read back via ADD with r0 and a zeroed register); opcode 0001 then ADD r0+r1 -> 0x0000.
- Assert rst mid-EXEC of an ADD -> outputs immediately at reset values, no out_valid, subsequent ADD r0+r1 -> 0x0000.
